// File: rtl/keypad_saw_voice_if.sv
// Keypad-voice bundle: keypad code in, decoded key, phase address and sawtooth sample out.
interface keypad_saw_voice_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned WIDTH      = 24
);
    logic [7:0]            kpyd_i;
    logic [3:0]            hex_o;
    logic                  key_pressed_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [WIDTH-1:0]      saw_o;
    logic                  valid_o;

    modport master (
        output kpyd_i,
        input  hex_o, key_pressed_o, addr_o, saw_o, valid_o
    );

    modport slave (
        input  kpyd_i,
        output hex_o, key_pressed_o, addr_o, saw_o, valid_o
    );
endinterface

// File: rtl/keypad_saw_voice.sv
// Single-voice keypad synth: 4x4 keypad decode, note phase accumulator, signed sawtooth output.
module keypad_saw_voice #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned FS_HZ      = 48000
) (
    input logic               clk_i,
    input logic               reset_i,
    keypad_saw_voice_if.slave bus
);
    // Nibble (row*4 + col) holds the key: row0 "123A", row1 "456B", row2 "789C", row3 "E0FD".
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic int unsigned note_hz(input int unsigned idx);
        case (idx)
            0:       return 261;
            1:       return 294;
            2:       return 330;
            3:       return 349;
            4:       return 392;
            5:       return 440;
            6:       return 494;
            7:       return 523;
            8:       return 587;
            9:       return 659;
            10:      return 698;
            11:      return 784;
            12:      return 880;
            13:      return 988;
            14:      return 1046;
            default: return 1174;
        endcase
    endfunction

    logic [ACC_WIDTH-1:0] inc_table [16];

    for (genvar k = 0; k < 16; k++) begin : g_inc
        localparam logic [63:0] NOTE_PROD = 64'(note_hz(k)) << ACC_WIDTH;
        assign inc_table[k] = ACC_WIDTH'(NOTE_PROD / 64'(FS_HZ));
    end

    logic [3:0]            row, col;
    logic [1:0]            row_idx, col_idx;
    logic                  legal;
    logic [3:0]            hex_q, hex_d;
    logic                  key_q;
    logic                  valid_q;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      saw_q, saw_d;

    assign row = bus.kpyd_i[7:4];
    assign col = bus.kpyd_i[3:0];

    always_comb begin
        row_idx = '0;
        col_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (row[i]) row_idx = 2'(i);
            if (col[i]) col_idx = 2'(i);
        end
        legal = $onehot(row) && $onehot(col);
        hex_d = legal ? KEY_MAP[{row_idx, col_idx, 2'b00} +: 4] : hex_q;
    end

    // The accumulator holds during the first post-reset edge so the first valid sample is acc=0.
    assign acc_d = valid_q ? acc_q + inc_table[hex_q] : acc_q;
    assign addr  = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH];
    assign saw_d = {~addr[ADDR_WIDTH-1], addr[ADDR_WIDTH-2:0], (WIDTH-ADDR_WIDTH)'(0)};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hex_q   <= '0;
            key_q   <= 1'b0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            saw_q   <= '0;
        end else begin
            hex_q   <= hex_d;
            key_q   <= legal;
            valid_q <= 1'b1;
            acc_q   <= acc_d;
            saw_q   <= saw_d;
        end
    end

    assign bus.hex_o         = hex_q;
    assign bus.key_pressed_o = key_q;
    assign bus.addr_o        = addr;
    assign bus.saw_o         = key_q ? saw_q : '0;
    assign bus.valid_o       = valid_q;
endmodule

// File: tb/tb_keypad_saw_voice.sv
// Directed bench for keypad_saw_voice: decode table, accumulator ramp, sawtooth wrap, async reset.
module tb_keypad_saw_voice;
    localparam logic [31:0] INC0 = 32'd23353884;
    localparam logic [31:0] INC5 = 32'd39370533;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    keypad_saw_voice_if bus_if ();

    keypad_saw_voice dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [23:0] saw_of(input logic [8:0] a);
        int v;
        v = (int'(a) * 32768) - 8388608;
        return v[23:0];
    endfunction

    logic [7:0]  codes [7];
    logic [3:0]  keys  [7];
    logic [31:0] model_acc;
    logic [8:0]  m_addr, m_prev, d_prev;
    int          dut_toggles, model_toggles;
    bit          wrapped, pending;

    initial begin
        checks   = 0;
        failures = 0;
        codes = '{8'h11, 8'h22, 8'h84, 8'h82, 8'h18, 8'h81, 8'h48};
        keys  = '{4'h1, 4'h5, 4'hF, 4'h0, 4'hA, 4'hE, 4'hC};

        rst = 1'b1;
        bus_if.kpyd_i = 8'h00;
        #12;
        check("rst_hex", 32'(bus_if.hex_o), 0);
        check("rst_key", 32'(bus_if.key_pressed_o), 0);
        check("rst_addr", 32'(bus_if.addr_o), 0);
        check("rst_saw", 32'(bus_if.saw_o), 0);
        check("rst_valid", 32'(bus_if.valid_o), 0);

        // Idle ramp on key 0.
        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle_valid", 32'(bus_if.valid_o), 1);
        check("idle_key", 32'(bus_if.key_pressed_o), 0);
        check("idle_saw", 32'(bus_if.saw_o), 0);
        check("idle_addr0", 32'(bus_if.addr_o), 0);
        for (int n = 1; n <= 3; n++) begin
            step();
            model_acc = INC0 * 32'(n);
            check("idle_addr", 32'(bus_if.addr_o), 32'(model_acc[31:23]));
            check("idle_saw_gated", 32'(bus_if.saw_o), 0);
        end

        // Legal keypad codes.
        for (int i = 0; i < 7; i++) begin
            bus_if.kpyd_i = codes[i];
            step();
            check("dec_hex", 32'(bus_if.hex_o), 32'(keys[i]));
            check("dec_key", 32'(bus_if.key_pressed_o), 1);
        end

        // Illegal codes hold the last key.
        bus_if.kpyd_i = 8'h33;
        step();
        check("multi_hex", 32'(bus_if.hex_o), 32'hC);
        check("multi_key", 32'(bus_if.key_pressed_o), 0);
        check("multi_saw", 32'(bus_if.saw_o), 0);
        bus_if.kpyd_i = 8'h00;
        step();
        check("none_hex", 32'(bus_if.hex_o), 32'hC);
        check("none_key", 32'(bus_if.key_pressed_o), 0);
        bus_if.kpyd_i = 8'h10;
        step();
        check("nocol_hex", 32'(bus_if.hex_o), 32'hC);
        check("nocol_key", 32'(bus_if.key_pressed_o), 0);

        // Reset then key 5.
        rst = 1'b1;
        bus_if.kpyd_i = 8'h22;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("k5_hex", 32'(bus_if.hex_o), 5);
        check("k5_addr0", 32'(bus_if.addr_o), 0);
        check("k5_saw0", 32'(bus_if.saw_o), 32'h800000);
        step();
        check("k5_addr1", 32'(bus_if.addr_o), 4);
        check("k5_saw1", 32'(bus_if.saw_o), 32'h800000);
        step();
        check("k5_addr2", 32'(bus_if.addr_o), 9);
        check("k5_saw2", 32'(bus_if.saw_o), 32'h820000);

        // One second of key 5 against a bench accumulator model.
        model_acc     = INC5 * 32'd2;
        m_prev        = model_acc[31:23];
        d_prev        = bus_if.addr_o;
        dut_toggles   = 0;
        model_toggles = 0;
        wrapped       = 1'b0;
        pending       = 1'b0;
        for (int i = 0; i < 48000; i++) begin
            step();
            model_acc = model_acc + INC5;
            m_addr    = model_acc[31:23];
            if (m_addr[8] != m_prev[8]) model_toggles++;
            if (bus_if.addr_o[8] != d_prev[8]) dut_toggles++;
            if (pending) begin
                check("wrap_saw_after", 32'(bus_if.saw_o), 32'(saw_of(m_prev)));
                pending = 1'b0;
            end
            if (!wrapped && m_addr < m_prev) begin
                wrapped = 1'b1;
                pending = 1'b1;
                check("wrap_addr", 32'(bus_if.addr_o), 32'(m_addr));
                check("wrap_saw_before", 32'(bus_if.saw_o), 32'(saw_of(m_prev)));
            end
            m_prev = m_addr;
            d_prev = bus_if.addr_o;
        end
        check("msb_toggles", 32'(dut_toggles), 32'(model_toggles));
        check("msb_toggles_range", 32'(dut_toggles >= 878 && dut_toggles <= 882), 1);
        check("ramp_end_addr", 32'(bus_if.addr_o), 32'(m_addr));

        // Asynchronous reset between edges.
        #1;
        rst = 1'b1;
        #1;
        check("arst_hex", 32'(bus_if.hex_o), 0);
        check("arst_key", 32'(bus_if.key_pressed_o), 0);
        check("arst_addr", 32'(bus_if.addr_o), 0);
        check("arst_saw", 32'(bus_if.saw_o), 0);
        check("arst_valid", 32'(bus_if.valid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("resume_addr0", 32'(bus_if.addr_o), 0);
        check("resume_hex", 32'(bus_if.hex_o), 5);
        step();
        check("resume_addr1", 32'(bus_if.addr_o), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
